// File: rtl/seq_checker.sv
// Memory-game round controller: captures an 8-bit pattern from a one-hot stream, shows it,
// then judges the player's entry. Optional consecutive-match score behind `SEQ_CHECK_SCORE_EN.
module seq_checker #(
    parameter int unsigned SHOW_CYCLES   = 50_000_000,
    parameter int unsigned RESULT_CYCLES = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SEQ,
    input  logic       START,
    input  logic [7:0] SW,
    input  logic       SUBMIT,
    output logic [7:0] LD,
    output logic [7:0] PATTERN,
    output logic       MATCH,
    output logic       FAIL,
    output logic       BUSY,
    output logic [3:0] SCORE
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHOW,
        WAIT_ENTRY,
        RESULT
    } state_t;

    state_t      state_reg;
    logic [2:0]  step_reg;
    logic [31:0] cnt_reg;
    logic        is_match;

    assign is_match = (SW == PATTERN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            cnt_reg   <= 32'd0;
            PATTERN   <= 8'h00;
            LD        <= 8'h00;
            MATCH     <= 1'b0;
            FAIL      <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // START wins over a simultaneous SUBMIT simply because SUBMIT is not looked at here.
                    if (START) begin
                        PATTERN   <= 8'h00;
                        step_reg  <= 3'd0;
                        state_reg <= CAPTURE;
                        BUSY      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    PATTERN  <= PATTERN | SEQ;
                    step_reg <= step_reg + 3'd1;
                    if (step_reg == 3'd7) begin
                        state_reg <= SHOW;
                        LD        <= PATTERN | SEQ;
                        cnt_reg   <= SHOW_CYCLES;
                    end
                end
                SHOW: begin
                    if (cnt_reg <= 32'd1) begin
                        state_reg <= WAIT_ENTRY;
                        LD        <= 8'h00;
                        cnt_reg   <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 32'd1;
                    end
                end
                WAIT_ENTRY: begin
                    if (SUBMIT) begin
                        state_reg <= RESULT;
                        MATCH     <= is_match;
                        FAIL      <= ~is_match;
                        LD        <= is_match ? 8'hFF : 8'h00;
                        cnt_reg   <= RESULT_CYCLES;
                    end
                end
                RESULT: begin
                    if (cnt_reg <= 32'd1) begin
                        state_reg <= IDLE;
                        MATCH     <= 1'b0;
                        FAIL      <= 1'b0;
                        LD        <= 8'h00;
                        BUSY      <= 1'b0;
                        cnt_reg   <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 32'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    LD        <= 8'h00;
                    MATCH     <= 1'b0;
                    FAIL      <= 1'b0;
                    BUSY      <= 1'b0;
                    cnt_reg   <= 32'd0;
                end
            endcase
        end
    end

`ifdef SEQ_CHECK_SCORE_EN
    logic [3:0] score_reg;

    // Score moves on the same edge that enters RESULT, so it lines up with MATCH/FAIL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            score_reg <= 4'd0;
        end else if (state_reg == WAIT_ENTRY && SUBMIT) begin
            if (!is_match) begin
                score_reg <= 4'd0;
            end else if (score_reg != 4'd15) begin
                score_reg <= score_reg + 4'd1;
            end
        end
    end

    assign SCORE = score_reg;
`else
    assign SCORE = 4'd0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Randomised scoreboard bench for seq_checker: the driver pushes expected show/result records,
// a negedge monitor pops them whenever the DUT shows a pattern or raises MATCH/FAIL.
module tb_seq_checker;

    localparam int SHOW = 4;
    localparam int RES  = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SEQ;
    logic       START;
    logic [7:0] SW;
    logic       SUBMIT;
    logic [7:0] LD;
    logic [7:0] PATTERN;
    logic       MATCH;
    logic       FAIL;
    logic       BUSY;
    logic [3:0] SCORE;

    seq_checker #(
        .SHOW_CYCLES   (SHOW),
        .RESULT_CYCLES (RES)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SEQ     (SEQ),
        .START   (START),
        .SW      (SW),
        .SUBMIT  (SUBMIT),
        .LD      (LD),
        .PATTERN (PATTERN),
        .MATCH   (MATCH),
        .FAIL    (FAIL),
        .BUSY    (BUSY),
        .SCORE   (SCORE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] pattern;
        logic       match;
        logic [3:0] score;
    } res_t;

    res_t       res_q[$];
    logic [7:0] show_q[$];
    int         checks = 0;
    int         errors = 0;
    int         score_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: result window = MATCH|FAIL high; show window = busy, no result, LD lit.
    logic       prev_mf = 1'b0;
    logic       prev_sh = 1'b0;
    logic       mf;
    logic       sh;
    int         res_len = 0;
    int         sh_len = 0;
    logic [7:0] sh_pat = 8'h00;
    res_t       r;

    always @(negedge CLK) begin
        mf = MATCH | FAIL;
        sh = BUSY && !mf && (LD != 8'h00);
        if (!RST) begin
            if (mf && !prev_mf) begin
                check("match_fail_exclusive", 32'(MATCH & FAIL), 32'd0);
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result match=%0b fail=%0b", MATCH, FAIL);
                end else begin
                    r = res_q.pop_front();
                    check("result_match", 32'(MATCH), 32'(r.match));
                    check("result_fail", 32'(FAIL), 32'(!r.match));
                    check("result_ld", 32'(LD), r.match ? 32'hFF : 32'h00);
                    check("result_pattern", 32'(PATTERN), 32'(r.pattern));
                    check("result_score", 32'(SCORE), 32'(r.score));
                end
                res_len = 1;
            end else if (mf) begin
                res_len++;
            end else if (prev_mf) begin
                check("result_len", 32'(res_len), 32'(RES));
                check("idle_after_result", 32'(BUSY), 32'd0);
            end

            if (sh && !prev_sh) begin
                if (show_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_show ld=%0h", LD);
                end else begin
                    sh_pat = show_q.pop_front();
                    check("show_ld", 32'(LD), 32'(sh_pat));
                end
                sh_len = 1;
            end else if (sh) begin
                sh_len++;
                check("show_ld_hold", 32'(LD), 32'(sh_pat));
            end else if (prev_sh) begin
                check("show_len", 32'(sh_len), 32'(SHOW));
                check("wait_ld_dark", 32'(LD), 32'd0);
            end
        end
        prev_mf = mf;
        prev_sh = sh;
    end

    task automatic expect_all_zero(input string tag);
        check({tag, "_pattern"}, 32'(PATTERN), 32'd0);
        check({tag, "_ld"}, 32'(LD), 32'd0);
        check({tag, "_match"}, 32'(MATCH), 32'd0);
        check({tag, "_fail"}, 32'(FAIL), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_score"}, 32'(SCORE), 32'd0);
    endtask

    task automatic run_round(input logic [7:0] seqv[8], input logic [7:0] sw, input int delay,
                             input bit pulse_in_show, input bit submit_with_start);
        logic [7:0] pat;
        bit         m;
        logic [3:0] exp_score;
        pat = 8'h00;
        for (int i = 0; i < 8; i++) pat |= seqv[i];
        show_q.push_back(pat);

        START  = 1'b1;
        SUBMIT = submit_with_start;
        SW     = ~pat;
        tick();
        START  = 1'b0;
        SUBMIT = 1'b0;
        check("busy_in_capture", 32'(BUSY), 32'd1);
        if (submit_with_start) begin
            check("start_wins_match", 32'(MATCH), 32'd0);
            check("start_wins_fail", 32'(FAIL), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            SEQ = seqv[i];
            tick();
        end
        SEQ = 8'h00;
        check("pattern_captured", 32'(PATTERN), 32'(pat));

        for (int i = 0; i < SHOW; i++) begin
            if (pulse_in_show && i == 1) begin
                START  = 1'b1;
                SUBMIT = 1'b1;
                SW     = pat;
            end
            tick();
            START  = 1'b0;
            SUBMIT = 1'b0;
        end
        repeat (delay) tick();

        m = (sw == pat);
        score_model = m ? ((score_model < 15) ? score_model + 1 : 15) : 0;
`ifdef SEQ_CHECK_SCORE_EN
        exp_score = 4'(score_model);
`else
        exp_score = 4'd0;
`endif
        res_q.push_back('{pat, m, exp_score});
        SW     = sw;
        SUBMIT = 1'b1;
        tick();
        SUBMIT = 1'b0;
        repeat (RES + 1) tick();
        check("pattern_held", 32'(PATTERN), 32'(pat));
    endtask

    task automatic rand_seq(output logic [7:0] seqv[8], output logic [7:0] pat);
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seqv[i] = ($urandom_range(0, 1) != 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
            pat |= seqv[i];
        end
        if (pat == 8'h00) begin
            seqv[7] = 8'd1 << $urandom_range(0, 7);
            pat     = seqv[7];
        end
    endtask

    logic [7:0] sv[8];
    logic [7:0] p;

    initial begin
        RST    = 1'b1;
        SEQ    = 8'h00;
        START  = 1'b0;
        SW     = 8'h00;
        SUBMIT = 1'b0;
        #2;
        expect_all_zero("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick();

        sv = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h20, 8'h00, 8'h80};
        run_round(sv, 8'hA5, 1, 1'b0, 1'b0);
        run_round(sv, 8'hA4, 0, 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            rand_seq(sv, p);
            run_round(sv, p, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        // Abort a round in its 5th capture cycle.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SEQ = 8'd1 << i;
            tick();
        end
        SEQ = 8'h00;
        check("pre_reset_pattern", 32'(PATTERN), 32'h0F);
        RST = 1'b1;
        #1;
        expect_all_zero("midcapture_reset");
        score_model = 0;
        tick();
        RST = 1'b0;
        tick();

        rand_seq(sv, p);
        run_round(sv, p, 0, 1'b0, 1'b1);
        rand_seq(sv, p);
        run_round(sv, p, 2, 1'b1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            rand_seq(sv, p);
            if ($urandom_range(0, 1) != 0) begin
                run_round(sv, p, int'($urandom_range(0, 3)), 1'b0, 1'b0);
            end else begin
                run_round(sv, p ^ (8'd1 << $urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
            end
        end

        repeat (3) tick();
        check("results_drained", 32'(res_q.size()), 32'd0);
        check("shows_drained", 32'(show_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
